fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Read-side consumer of dual_clk_fifo. Runs entirely in the read clock domain.
//  Pops bytes from the FIFO and packs BYTES_PER_WORD of them into one word,
//  little-endian (first byte popped -> bits [7:0]).
//  Presents each word on a valid/ready interface to the downstream datapath.
//  A flush request emits a partial word with a byte-enable mask.
// PARAMETERS
//  DATA_W          8   FIFO byte width
//  BYTES_PER_WORD  4   bytes per output word (>=2)
//  CNT_W           16  width of bytes_packed counter
// PORTS
//  clk_r         in   1                      read-domain clock, all logic on posedge
//  rst_n         in   1                      asynchronous active-low reset
//  fifo_dout     in   DATA_W                 connects to FIFO buf_out
//  fifo_empty    in   1                      connects to FIFO buf_empty
//  fifo_rd_en    out  1                      connects to FIFO rd_en
//  flush         in   1                      1-cycle pulse: close current word early
//  word_out      out  DATA_W*BYTES_PER_WORD  packed word
//  word_be       out  BYTES_PER_WORD         byte-valid mask for word_out
//  word_valid    out  1                      word_out/word_be valid
//  word_ready    in   1                      downstream accepts word
//  bytes_packed  out  CNT_W                  running count of bytes captured
//  busy          out  1                      1 when fill_cnt!=0, a read is pending, or state!=FILL
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FILL, fill_cnt=0, rd_pend=0, flush_req=0.
//    All outputs 0. Holding register cleared; any in-flight byte is discarded.
//  - FIFO read latency is 1 cycle: fifo_dout is captured the cycle after fifo_rd_en=1.
//    rd_pend is a register holding the previous cycle's fifo_rd_en.
//  - fifo_rd_en = state==FILL & !fifo_empty & !flush_req & (fill_cnt+rd_pend < BYTES_PER_WORD).
//    fifo_rd_en is combinational. Back-to-back reads are allowed.
//  - Capture: when rd_pend=1, lane[fill_cnt] <= fifo_dout, fill_cnt++, bytes_packed++.
//    bytes_packed wraps modulo 2^CNT_W.
//  - States:
//    FILL -> OUT    when a capture makes fill_cnt==BYTES_PER_WORD.
//                   word_be = all ones.
//    FILL -> DRAIN  when flush=1 (sets flush_req).
//    DRAIN -> OUT   when rd_pend=0 and fill_cnt>0.
//                   word_be = (1<<fill_cnt)-1. Unfilled lanes read 0.
//    DRAIN -> FILL  when rd_pend=0 and fill_cnt==0. No word is emitted.
//    OUT -> FILL    on word_valid & word_ready.
//                   fill_cnt=0, lanes cleared, flush_req=0.
//  - DRAIN still captures the one in-flight byte; that byte belongs to the flushed word.
//  - word_valid is registered and is 1 exactly in OUT. It rises the cycle after the last capture.
//  - word_out/word_be stay stable while word_valid=1 & word_ready=0. No FIFO reads occur in OUT.
//  - flush is ignored in DRAIN and OUT (no queuing).
//  - flush in the same cycle as the capture that completes a word: the full word wins (->OUT);
//    the flush is dropped.
//  - word_ready while word_valid=0 has no effect.
//  - Deasserting rst_n mid-word loses that word. The FIFO itself is not reset by this block.
// TESTING
//  1 FIFO fed 10,20,30,40; word_ready=1 -> one word 0x281E140A, be=4'hF; bytes_packed=4.
//  2 FIFO fed 10..50 step 10; flush after 5th capture -> 0x281E140A be=F,
//    then 0x00000032 be=4'h1; fifo_rd_en stays low during DRAIN/OUT.
//  3 8 bytes queued, word_ready=0 for 10 cycles -> word_out held constant,
//    fifo_rd_en=0, then 2 words delivered in order once word_ready=1.
//  4 flush pulse with fill_cnt=0 and FIFO empty -> no word_valid; returns to FILL in 1 cycle.
//  5 rst_n low after 2 captures -> all outputs 0 next edge; restart with 4 new bytes
//    -> word contains only the new bytes.
//  6 CNT_W=4, 17 bytes streamed -> bytes_packed=1; 4 full words plus 1 byte held,
//    then flush -> be=4'h1.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Read-domain consumer of dual_clk_fifo: pops bytes, packs them little-endian into
// words, and hands each word downstream on a valid/ready interface.
module fifo_word_packer #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int CNT_W          = 16
) (
   input  logic                             clk_r,
   input  logic                             rst_n,
   input  logic [DATA_W-1:0]                fifo_dout,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_en,
   input  logic                             flush,
   output logic [DATA_W*BYTES_PER_WORD-1:0] word_out,
   output logic [BYTES_PER_WORD-1:0]        word_be,
   output logic                             word_valid,
   input  logic                             word_ready,
   output logic [CNT_W-1:0]                 bytes_packed,
   output logic                             busy
);

   localparam int FC_W = $clog2(BYTES_PER_WORD + 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t                                 state;
   logic [FC_W-1:0]                        fill_cnt;
   logic                                   rd_pend;
   logic                                   flush_req;
   logic [BYTES_PER_WORD-1:0][DATA_W-1:0]  lanes;
   logic                                   capture;
   logic                                   word_done;
   logic [FC_W:0]                          slots_used;

   function automatic logic [BYTES_PER_WORD-1:0] be_mask(input logic [FC_W-1:0] n);
      logic [BYTES_PER_WORD-1:0] m;
      m = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (FC_W'(i) < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // A pending read already owns a lane, so it counts against the word's capacity.
   assign slots_used = {1'b0, fill_cnt} + {{FC_W{1'b0}}, rd_pend};
   assign capture    = rd_pend;
   assign word_done  = capture && (fill_cnt == FC_W'(BYTES_PER_WORD - 1));

   assign fifo_rd_en = rst_n && (state == FILL) && !fifo_empty && !flush_req &&
                       (slots_used < (FC_W+1)'(BYTES_PER_WORD));
   assign word_out   = lanes;
   assign busy       = (fill_cnt != '0) || rd_pend || (state != FILL);

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FILL;
         fill_cnt     <= '0;
         rd_pend      <= 1'b0;
         flush_req    <= 1'b0;
         lanes        <= '0;
         word_be      <= '0;
         word_valid   <= 1'b0;
         bytes_packed <= '0;
      end else begin
         rd_pend <= fifo_rd_en;

         if (capture) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
               if (fill_cnt == FC_W'(i)) lanes[i] <= fifo_dout;
            end
            fill_cnt     <= fill_cnt + FC_W'(1);
            bytes_packed <= bytes_packed + CNT_W'(1);
         end

         case (state)
            FILL: begin
               // A completing capture takes priority over a same-cycle flush.
               if (word_done) begin
                  state      <= OUT;
                  word_valid <= 1'b1;
                  word_be    <= '1;
               end else if (flush) begin
                  state     <= DRAIN;
                  flush_req <= 1'b1;
               end
            end
            DRAIN: begin
               if (!rd_pend) begin
                  if (fill_cnt != '0) begin
                     state      <= OUT;
                     word_valid <= 1'b1;
                     word_be    <= be_mask(fill_cnt);
                  end else begin
                     state     <= FILL;
                     flush_req <= 1'b0;
                  end
               end
            end
            OUT: begin
               if (word_ready) begin
                  state      <= FILL;
                  word_valid <= 1'b0;
                  word_be    <= '0;
                  fill_cnt   <= '0;
                  lanes      <= '0;
                  flush_req  <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a byte-queue FIFO model feeds the DUT,
// expected words are queued by the stimulus and checked by a forked monitor.
module tb_fifo_word_packer;

   typedef struct packed {
      logic [31:0] word;
      logic [3:0]  be;
   } exp_t;

   logic        clk_r;
   logic        rst_n;
   logic [7:0]  fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        flush;
   logic [31:0] word_out;
   logic [3:0]  word_be;
   logic        word_valid;
   logic        word_ready;
   logic [3:0]  bytes_packed;
   logic        busy;

   int          checks;
   int          failures;
   exp_t        sb_q[$];

   logic [7:0]  mem [256];
   int          wr_cnt;
   int          rd_cnt;

   fifo_word_packer #(
      .DATA_W        (8),
      .BYTES_PER_WORD(4),
      .CNT_W         (4)
   ) dut (
      .clk_r       (clk_r),
      .rst_n       (rst_n),
      .fifo_dout   (fifo_dout),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .flush       (flush),
      .word_out    (word_out),
      .word_be     (word_be),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .bytes_packed(bytes_packed),
      .busy        (busy)
   );

   initial begin
      clk_r = 1'b0;
      forever #5 clk_r = ~clk_r;
   end

   // FIFO model with one-cycle read latency
   assign fifo_empty = (wr_cnt == rd_cnt);

   always @(posedge clk_r) begin
      if (fifo_rd_en && (rd_cnt != wr_cnt)) begin
         fifo_dout <= mem[rd_cnt];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_r);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_cnt] = b;
      wr_cnt++;
   endtask

   task automatic expect_word(input logic [31:0] w, input logic [3:0] be);
      exp_t e;
      e.word = w;
      e.be   = be;
      sb_q.push_back(e);
   endtask

   task automatic wait_bp(input string name, input logic [3:0] target);
      for (int i = 0; i < 60 && bytes_packed != target; i++) @(negedge clk_r);
      check(name, 32'(bytes_packed), 32'(target));
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && (sb_q.size() != 0 || word_valid); i++) @(negedge clk_r);
      check(name, 32'(sb_q.size() == 0 && !word_valid), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_word_valid"},   32'(word_valid),   32'd0);
      check({tag, "_word_be"},      32'(word_be),      32'd0);
      check({tag, "_word_out"},     word_out,          32'd0);
      check({tag, "_bytes_packed"}, 32'(bytes_packed), 32'd0);
      check({tag, "_busy"},         32'(busy),         32'd0);
      check({tag, "_fifo_rd_en"},   32'(fifo_rd_en),   32'd0);
   endtask

   task automatic pulse_flush();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      logic acc;
      checks     = 0;
      failures   = 0;
      wr_cnt     = 0;
      rd_cnt     = 0;
      rst_n      = 1'b0;
      flush      = 1'b0;
      word_ready = 1'b1;

      fork
         forever begin
            @(negedge clk_r);
            if (rst_n && word_valid && word_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_word actual=0x%0h be=0x%0h expected=none", word_out, word_be);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check("sb_word", word_out, e.word);
                  check("sb_be", 32'(word_be), 32'(e.be));
               end
            end
         end
      join_none

      repeat (2) tick();
      check_reset_outputs("rst0");
      rst_n = 1'b1;

      // Test 1: one full word
      tick();
      push_byte(8'd10); push_byte(8'd20); push_byte(8'd30); push_byte(8'd40);
      expect_word(32'h281E140A, 4'hF);
      wait_bp("t1_bytes_packed", 4'd4);
      wait_drain("t1_drain");

      // Test 2: flush after the 5th capture, reads blocked in DRAIN/OUT
      tick();
      push_byte(8'd10); push_byte(8'd20); push_byte(8'd30); push_byte(8'd40); push_byte(8'd50);
      expect_word(32'h281E140A, 4'hF);
      expect_word(32'h00000032, 4'h1);
      wait_bp("t2_five_captured", 4'd9);
      pulse_flush();
      push_byte(8'h3C);
      acc = 1'b0;
      for (int k = 0; k < 6 && !acc; k++) begin
         @(negedge clk_r);
         check("t2_rd_en_drain_out", 32'(fifo_rd_en), 32'd0);
         if (word_valid && word_ready) acc = 1'b1;
      end
      check("t2_partial_accepted", 32'(acc), 32'd1);
      expect_word(32'h0000003C, 4'h1);
      wait_bp("t2_after_3c", 4'd10);
      pulse_flush();
      wait_drain("t2_drain");

      // Test 3: backpressure holds the word and stops reads
      tick();
      word_ready = 1'b0;
      for (int b = 1; b <= 8; b++) push_byte(8'(b));
      expect_word(32'h04030201, 4'hF);
      expect_word(32'h08070605, 4'hF);
      for (int i = 0; i < 30 && !word_valid; i++) @(negedge clk_r);
      check("t3_valid_seen", 32'(word_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_r);
         check("t3_hold_word", word_out, 32'h04030201);
         check("t3_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      end
      tick();
      word_ready = 1'b1;
      wait_drain("t3_drain");
      check("t3_bytes_packed", 32'(bytes_packed), 32'd2);

      // Test 4: flush with nothing to send
      pulse_flush();
      @(negedge clk_r);
      check("t4_busy_drain", 32'(busy), 32'd1);
      @(negedge clk_r);
      check("t4_busy_back_fill", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_r);
         check("t4_no_valid", 32'(word_valid), 32'd0);
      end

      // Test 5: reset mid-word discards the partial word
      tick();
      push_byte(8'hAA); push_byte(8'hBB);
      wait_bp("t5_two_captured", 4'd4);
      check("t5_busy_mid_word", 32'(busy), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      tick();
      check_reset_outputs("t5_rst_edge");
      rst_n = 1'b1;
      tick();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      expect_word(32'h44332211, 4'hF);
      wait_drain("t5_drain");
      check("t5_bytes_packed", 32'(bytes_packed), 32'd4);

      // Test 6: counter wrap with 17 bytes, then flush the leftover byte
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int b = 1; b <= 17; b++) push_byte(8'(b));
      expect_word(32'h04030201, 4'hF);
      expect_word(32'h08070605, 4'hF);
      expect_word(32'h0C0B0A09, 4'hF);
      expect_word(32'h100F0E0D, 4'hF);
      wait_drain("t6_four_words");
      repeat (5) @(negedge clk_r);
      check("t6_bytes_packed_wrap", 32'(bytes_packed), 32'd1);
      check("t6_busy_held_byte", 32'(busy), 32'd1);
      check("t6_no_valid", 32'(word_valid), 32'd0);
      expect_word(32'h00000011, 4'h1);
      pulse_flush();
      wait_drain("t6_flush_drain");

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
